// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge
//   Converts the MMU's single-outstanding physical memory request into one
//   AXI4-Lite master transaction. A read runs AR then R. A write runs AW and W
//   in parallel, then B. Completion is a one-cycle response_enable pulse. The
//   pulse carries resp_data, which is zero for writes and for errors, and
//   resp_error. Both fields hold until the next response.
//
//   Optional feature: define MEM_BRIDGE_TIMEOUT_EN to add a bus-timeout
//   watchdog. It is controlled by the TIMEOUT_CYCLES parameter. When it fires,
//   the bridge forces an error response. It then drains the outstanding
//   handshakes in a RECOVER state before it accepts new work.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   request_enable         request strobe, sampled only while idle
//   req_mode               0 = read, 1 = write
//   req_addr/wdata/wstrb   request payload, latched on acceptance
//   response_enable        one-cycle completion pulse
//   resp_data, resp_error  completion payload
//   m_axi_*                AXI4-Lite master (AR, R, AW, W, B channels)
module mem_axi_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request_enable,
  input  logic        req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        response_enable,
  output logic [31:0] resp_data,
  output logic        resp_error,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic [2:0]  m_axi_arprot,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [2:0]  m_axi_awprot,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP, S_DONE
`ifdef MEM_BRIDGE_TIMEOUT_EN
    , S_RECOVER
`endif
  } state_e;

  state_e      state_q;
  logic        response_enable_q, resp_error_q;
  logic [31:0] resp_data_q, araddr_q, awaddr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;

  // Handshakes that complete at the coming edge.
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  // A write address or data beat that is still pending after the coming edge.
  logic aw_left, w_left;
  assign ar_hs   = arvalid_q & m_axi_arready;
  assign r_hs    = rready_q  & m_axi_rvalid;
  assign aw_hs   = awvalid_q & m_axi_awready;
  assign w_hs    = wvalid_q  & m_axi_wready;
  assign b_hs    = bready_q  & m_axi_bvalid;
  assign aw_left = awvalid_q & ~m_axi_awready;
  assign w_left  = wvalid_q  & ~m_axi_wready;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  // The counter is 0 in the first cycle after acceptance. Firing at
  // TIMEOUT_CYCLES-2 places the forced response TIMEOUT_CYCLES cycles after
  // the request cycle.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 2);
  logic [15:0] cnt_q;
  logic        ar_left, r_left, b_left, busy, finishing;
  assign ar_left   = arvalid_q & ~m_axi_arready;
  // R becomes owed the moment AR completes.
  assign r_left    = (rready_q & ~m_axi_rvalid) | ar_hs;
  // B becomes owed once the last of AW/W completes.
  assign b_left    = (bready_q & ~m_axi_bvalid) |
                     ((awvalid_q | wvalid_q) & ~aw_left & ~w_left);
  assign busy      = (state_q == S_RD_ADDR) || (state_q == S_RD_DATA) ||
                     (state_q == S_WR_REQ)  || (state_q == S_WR_RESP);
  assign finishing = ((state_q == S_RD_DATA) && r_hs) ||
                     ((state_q == S_WR_RESP) && b_hs);
`endif

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then sees pre-edge values, and a later assignment to the same register in
  // this block overrides an earlier one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      response_enable_q <= 1'b0;
      resp_error_q      <= 1'b0;
      resp_data_q       <= '0;
      araddr_q          <= '0;
      awaddr_q          <= '0;
      wdata_q           <= '0;
      wstrb_q           <= '0;
      arvalid_q         <= 1'b0;
      rready_q          <= 1'b0;
      awvalid_q         <= 1'b0;
      wvalid_q          <= 1'b0;
      bready_q          <= 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      cnt_q             <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (request_enable) begin
            if (req_mode) begin
              awaddr_q  <= req_addr;
              wdata_q   <= req_wdata;
              wstrb_q   <= req_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_WR_REQ;
            end else begin
              araddr_q  <= req_addr;
              arvalid_q <= 1'b1;
              state_q   <= S_RD_ADDR;
            end
          end
        end
        S_RD_ADDR: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (r_hs) begin
            rready_q          <= 1'b0;
            resp_error_q      <= |m_axi_rresp;
            resp_data_q       <= (|m_axi_rresp) ? '0 : m_axi_rdata;
            response_enable_q <= 1'b1;
            state_q           <= S_DONE;
          end
        end
        S_WR_REQ: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          if (!aw_left && !w_left) begin
            bready_q <= 1'b1;
            state_q  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (b_hs) begin
            bready_q          <= 1'b0;
            resp_error_q      <= |m_axi_bresp;
            resp_data_q       <= '0;
            response_enable_q <= 1'b1;
            state_q           <= S_DONE;
          end
        end
        S_DONE: begin
          response_enable_q <= 1'b0;
          state_q           <= S_IDLE;
        end
`ifdef MEM_BRIDGE_TIMEOUT_EN
        S_RECOVER: begin
          // Finish the abandoned transaction on the bus and discard its result.
          response_enable_q <= 1'b0;
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
          if (r_hs)  rready_q  <= 1'b0;
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          if ((awvalid_q | wvalid_q) && !aw_left && !w_left) bready_q <= 1'b1;
          if (b_hs)  bready_q  <= 1'b0;
          if (!ar_left && !r_left && !aw_left && !w_left && !b_left)
            state_q <= S_IDLE;
        end
`endif
        default: state_q <= S_IDLE;
      endcase

`ifdef MEM_BRIDGE_TIMEOUT_EN
      if (state_q == S_IDLE) begin
        if (request_enable) cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
      // Timeout overrides the state branch above. A completion on the same
      // edge still wins. Channel signals keep the values the branch gave them,
      // so RECOVER sees exactly what remains outstanding.
      if (busy && !finishing && (cnt_q == TO_LAST)) begin
        response_enable_q <= 1'b1;
        resp_error_q      <= 1'b1;
        resp_data_q       <= '0;
        state_q           <= S_RECOVER;
      end
`endif
    end
  end

  assign response_enable = response_enable_q;
  assign resp_data       = resp_data_q;
  assign resp_error      = resp_error_q;
  assign m_axi_araddr    = araddr_q;
  assign m_axi_arvalid   = arvalid_q;
  assign m_axi_arprot    = 3'b000;
  assign m_axi_rready    = rready_q;
  assign m_axi_awaddr    = awaddr_q;
  assign m_axi_awvalid   = awvalid_q;
  assign m_axi_awprot    = 3'b000;
  assign m_axi_wdata     = wdata_q;
  assign m_axi_wstrb     = wstrb_q;
  assign m_axi_wvalid    = wvalid_q;
  assign m_axi_bready    = bready_q;

endmodule
